// File: rtl/barrido_registros.sv
// rtl/barrido_registros.sv - periodic scan of RTC registers into a frame-aligned display snapshot
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   datmen            register memory read data (valid the cycle after readmen)
//   vsync_in          frame-start level; its rising edge releases a pending snapshot
//   readmen           register memory read strobe
//   ADDreadreg        register memory read address
//   seg..chora        committed BCD snapshot (time, date, chronometer)
//   valid             one-cycle pulse when a snapshot is committed
//   scan_busy         high while a scan/commit is in progress
//   bcd_error         sticky flag: last snapshot was discarded for bad BCD
//
// Optional feature: define BARRIDO_BCD_CHECK_EN to validate BCD nibbles and
// discard snapshots that contain a non-decimal digit.

module barrido_registros #(
    parameter int NUM_REGS    = 9,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] datmen,
    input  logic       vsync_in,
    output logic       readmen,
    output logic [3:0] ADDreadreg,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] cseg,
    output logic [7:0] cmin,
    output logic [7:0] chora,
    output logic       valid,
    output logic       scan_busy,
    output logic       bcd_error
);

    // Nine named output registers; NUM_REGS may scan fewer but never more.
    localparam int         NUM_OUT  = 9;
    localparam int         CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        SYNC,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q;
    logic          vs_prev_q;
    logic [7:0]    shadow_q [NUM_OUT];
    logic [7:0]    out_q    [NUM_OUT];
    logic          tick;
    logic          vs_edge;
    logic          discard;

    assign tick    = (cnt_q == CNT_LAST);
    assign vs_edge = vsync_in & ~vs_prev_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state; ticks outside IDLE are simply ignored
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = REQ;
                end
            end
            REQ:  state_d = CAPT;
            CAPT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = SYNC;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = REQ;
                end
            end
            SYNC: begin
                if (vs_edge) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ADDreadreg follows idx, which only moves on a tick or in CAPT, so it
    // naturally holds the last driven address in IDLE/SYNC/COMMIT.
    assign readmen    = (state_q == REQ);
    assign ADDreadreg = idx_q;
    assign scan_busy  = (state_q != IDLE);

`ifdef BARRIDO_BCD_CHECK_EN
    logic flag_q;
    logic err_q;
    logic nib_bad;

    assign nib_bad = (datmen[7:4] > 4'd9) || (datmen[3:0] > 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && tick) begin
                flag_q <= 1'b0;
            end else if (state_q == CAPT) begin
                flag_q <= flag_q | nib_bad;
            end
            if (state_q == SYNC && vs_edge) begin
                err_q <= flag_q;
            end
        end
    end

    // flag_q is frozen from the last CAPT until the next scan starts
    assign discard   = flag_q;
    assign bcd_error = err_q;
`else
    assign discard   = 1'b0;
    assign bcd_error = 1'b0;
`endif

    // Datapath: refresh counter, vsync history, shadow capture, output commit.
    // Outputs load on the edge into COMMIT so they are valid alongside the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            vs_prev_q <= 1'b0;
            for (int i = 0; i < NUM_OUT; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            cnt_q     <= tick ? '0 : cnt_q + CW'(1);
            vs_prev_q <= vsync_in;
            if (state_q == CAPT) begin
                shadow_q[idx_q] <= datmen;
            end
            if (state_q == SYNC && vs_edge && !discard) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    out_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign valid = (state_q == COMMIT) && !discard;

    assign seg   = out_q[0];
    assign min   = out_q[1];
    assign hora  = out_q[2];
    assign dia   = out_q[3];
    assign mes   = out_q[4];
    assign anio  = out_q[5];
    assign cseg  = out_q[6];
    assign cmin  = out_q[7];
    assign chora = out_q[8];

endmodule

// File: tb/tb_barrido_registros.sv
// tb/tb_barrido_registros.sv - scoreboard bench for barrido_registros

module tb_barrido_registros;

    localparam int NREG = 9;
    localparam int DIV  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] datmen = 8'h00;
    logic       vsync_in = 1'b0;
    logic       readmen;
    logic [3:0] ADDreadreg;
    logic [7:0] seg, min, hora, dia, mes, anio, cseg, cmin, chora;
    logic       valid, scan_busy, bcd_error;

    always #5 clk = ~clk;

    barrido_registros #(
        .NUM_REGS   (NREG),
        .REFRESH_DIV(DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .datmen    (datmen),
        .vsync_in  (vsync_in),
        .readmen   (readmen),
        .ADDreadreg(ADDreadreg),
        .seg       (seg),
        .min       (min),
        .hora      (hora),
        .dia       (dia),
        .mes       (mes),
        .anio      (anio),
        .cseg      (cseg),
        .cmin      (cmin),
        .chora     (chora),
        .valid     (valid),
        .scan_busy (scan_busy),
        .bcd_error (bcd_error)
    );

    logic [71:0] dut_out;
    assign dut_out = {chora, cmin, cseg, anio, mes, dia, hora, min, seg};

    typedef struct packed {
        logic [71:0] out;
        logic [1:0]  nvalid;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem [NREG];
    logic [71:0] ref_out = '0;
    logic        ref_err = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout", name);
    endtask

    // Register memory: answers one cycle after the strobe, garbage otherwise
    initial begin
        logic       p;
        logic [3:0] a;
        forever begin
            @(negedge clk);
            p = readmen;
            a = ADDreadreg;
            @(posedge clk);
            #1;
            if (p === 1'b1 && a < 4'(NREG)) datmen = mem[a];
            else datmen = 8'($urandom);
        end
    end

    // Monitor: protocol checks every cycle, snapshot checks at end of each scan
    initial begin
        logic        prev_busy = 1'b0;
        logic        prev_rd = 1'b0;
        int          k = 0;
        int          rd_cnt = 0;
        int          vcnt = 0;
        logic [71:0] cur = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                k = 0; rd_cnt = 0; vcnt = 0; cur = '0;
                prev_busy = 1'b0; prev_rd = 1'b0;
                sb_q.delete();
            end else begin
                k++;
                if (readmen) begin
                    chk("rd_gap", 72'(prev_rd), 72'(0));
                    chk("rd_addr", 72'(ADDreadreg), 72'(rd_cnt));
                    rd_cnt = (rd_cnt + 1) % NREG;
                end
                if (scan_busy && !prev_busy) chk("start_phase", 72'((k - 1) % DIV), 72'(0));
                if (!scan_busy && prev_busy) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_scan");
                    end else begin
                        e = sb_q.pop_front();
                        chk("nvalid", 72'(vcnt), 72'(e.nvalid));
                        chk("scan_out", dut_out, e.out);
                        chk("bcd_error", 72'(bcd_error), 72'(e.err));
                        cur = e.out;
                    end
                    vcnt = 0;
                end
                if (valid) begin
                    vcnt++;
                    if (sb_q.size() > 0) chk("commit_data", dut_out, sb_q[0].out);
                    else fail_now("unexpected_valid");
                end else begin
                    chk("hold", dut_out, cur);
                end
                prev_busy = scan_busy;
                prev_rd   = readmen;
            end
        end
    end

    // One scan: load memory, predict the outcome, then drive vsync at cycle
    // offsets counted from the first REQ (SYNC is entered at offset 18).
    task automatic run_scan(input logic [71:0] m, input int r1, input int f1, input int r2);
        exp_t e;
        int   eff;
        int   n;
        bit   bad = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            mem[i] = m[8*i +: 8];
            if (m[8*i+4 +: 4] > 4'd9 || m[8*i +: 4] > 4'd9) bad = 1'b1;
        end
`ifdef BARRIDO_BCD_CHECK_EN
        if (bad) begin
            ref_err = 1'b1;
            e = '{out: ref_out, nvalid: 2'd0, err: 1'b1};
        end else begin
            ref_out = m; ref_err = 1'b0;
            e = '{out: m, nvalid: 2'd1, err: 1'b0};
        end
`else
        ref_out = m; ref_err = 1'b0;
        e = '{out: m, nvalid: 2'd1, err: 1'b0};
`endif
        sb_q.push_back(e);
        n = 0;
        while (!scan_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!scan_busy) begin
            fail_now("scan_start");
            return;
        end
        eff = (r1 >= 2 * NREG) ? r1 : r2;
        for (int c = 1; c <= eff; c++) begin
            @(negedge clk);
            if (c == r1) vsync_in = 1'b1;
            if (c == f1) vsync_in = 1'b0;
            if (c == r2) vsync_in = 1'b1;
        end
        n = eff;
        while (scan_busy && n < eff + 100) begin
            @(negedge clk);
            n++;
        end
        vsync_in = 1'b0;
        chk("commit_time", 72'(n), 72'(eff + 2));
    endtask

    function automatic logic [71:0] rand_bcd();
        logic [71:0] v;
        for (int i = 0; i < NREG; i++)
            v[8*i +: 8] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        return v;
    endfunction

    task automatic reset_mid_scan();
        int n = 0;
        while (!(readmen && ADDreadreg == 4'd4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("reach_idx4");
            return;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_readmen", 72'(readmen), 72'(0));
        chk("rst_busy", 72'(scan_busy), 72'(0));
        chk("rst_valid", 72'(valid), 72'(0));
        chk("rst_out", dut_out, 72'(0));
        chk("rst_err", 72'(bcd_error), 72'(0));
        ref_out = '0;
        ref_err = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [71:0] m;
        for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_out", dut_out, 72'(0));
        chk("reset_ctrl", 72'({readmen, valid, scan_busy, bcd_error, ADDreadreg}), 72'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < NREG; i++) m[8*i +: 8] = 8'(i);
        run_scan(m, 18, -1, -1);
        run_scan(rand_bcd(), 15, 25, 28);   // vsync already high before SYNC
        run_scan(rand_bcd(), 17, 20, 22);   // edge coincides with last CAPT
        run_scan(rand_bcd(), 48, -1, -1);   // refresh tick lands inside SYNC
        for (int s = 0; s < 4; s++)
            run_scan(rand_bcd(), 18 + int'($urandom_range(0, 15)), -1, -1);
        m = rand_bcd();
        m[23:16] = 8'h3A;
        run_scan(m, 18, -1, -1);
        run_scan(rand_bcd(), 19, -1, -1);
        m = rand_bcd();
        m[71:64] = 8'hA5;
        run_scan(m, 20, -1, -1);
        run_scan(rand_bcd(), 18, -1, -1);
        reset_mid_scan();
        run_scan(rand_bcd(), 18, -1, -1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 72'(sb_q.size()), 72'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/barrido_registros.md
Name: barrido_registros

Overview:
- Downstream consumer of the RTC control block's register memory read port (ADDreadreg / readmen / datmen).
- Periodically scans the 9 time/date/chrono registers in order and captures them into a shadow set.
- Optionally validates the BCD content of each register.
- Publishes the shadow set to the display stage as one coherent snapshot, aligned to a frame-start pulse, so the screen never shows a half-updated time.

Parameters:
- NUM_REGS, 9, number of registers scanned; address 0..NUM_REGS-1 = seg, min, hora, dia, mes, anio, cseg, cmin, chora.
- REFRESH_DIV, 100000, clk cycles between scan start ticks (minimum 32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- datmen  in  8  register memory read data; valid the cycle after readmen=1.
- vsync_in  in  1  frame-start level from the video timing block; rising edge is detected internally.
- readmen  out  1  register memory read strobe.
- ADDreadreg  out  4  register memory read address.
- seg, min, hora  out  8 each  committed BCD seconds, minutes, hours.
- dia, mes, anio  out  8 each  committed BCD day, month, year.
- cseg, cmin, chora  out  8 each  committed BCD chronometer seconds, minutes, hours.
- valid  out  1  one-cycle pulse on each commit.
- scan_busy  out  1  high from REQ through COMMIT.
- bcd_error  out  1  sticky flag for a discarded snapshot (see Optional Feature).

Behaviour:
- Reset, synchronous and dominant, including mid-scan:
  - all outputs 0; FSM to IDLE; idx=0.
  - refresh counter 0; shadow registers 0; vsync edge detector history 0.
- Refresh counter:
  - free-running 0..REFRESH_DIV-1; tick when it reaches REFRESH_DIV-1, then wraps to 0.
  - a tick while FSM is not IDLE is dropped; it is not queued.
- FSM states and transitions:
  - IDLE: readmen=0. On tick: idx<=0, go REQ.
  - REQ: readmen=1, ADDreadreg=idx. Go CAPT.
  - CAPT: readmen=0, ADDreadreg holds idx, shadow[idx]<=datmen.
    - if idx==NUM_REGS-1, go SYNC; else idx<=idx+1, go REQ.
  - SYNC: readmen=0; wait for a vsync_in rising edge (vsync_in=1 with previous sample 0). Go COMMIT in the cycle after the edge.
  - COMMIT: all 9 outputs <= shadow in the same cycle; valid=1 for this cycle only; go IDLE.
- Timing:
  - scan length: 2*NUM_REGS cycles (18 at default) from first REQ to entering SYNC.
  - outputs change only in COMMIT and never partially.
- readmen is high exactly one cycle per register, never in two consecutive cycles.
- ADDreadreg in IDLE/SYNC/COMMIT holds the last driven value.
- vsync_in held high when entering SYNC is not an edge; a fresh 0->1 transition is required.
- An edge in the same cycle as the last CAPT is not counted; it must occur while in SYNC.
- scan_busy = (state != IDLE).

Optional Feature:
- Macro: BARRIDO_BCD_CHECK_EN.
- Defined:
  - in each CAPT, flag the register if either nibble of datmen > 9; the flag accumulates over the scan.
  - COMMIT with any flagged register: outputs keep their previous values, valid stays 0, bcd_error<=1.
  - bcd_error is cleared only by reset or by the next clean COMMIT.
  - the accumulator clears on entering REQ with idx=0.
- Undefined:
  - no check is made; every scan commits.
  - bcd_error is constant 0.

Test Plan:
- Reset during CAPT of idx=4 -> next cycle readmen=0, all outputs 0, scan_busy=0; the next tick starts at idx=0.
- Memory model returns 0x00..0x08 for addresses 0..8, REFRESH_DIV=40 -> readmen pulses at addresses 0..8 on alternate cycles.
  - After the vsync rise: seg=0x00 ... chora=0x08, valid high for 1 cycle.
- vsync_in held high before the scan ends -> no commit until vsync_in falls and rises again; outputs unchanged meanwhile.
- Tick issued while in SYNC -> tick ignored; exactly one commit; the next scan starts only on the following tick.
- With BARRIDO_BCD_CHECK_EN, address 2 returns 0x3A -> outputs keep prior snapshot, valid=0, bcd_error=1.
  - The next clean scan commits and clears bcd_error.
- Without BARRIDO_BCD_CHECK_EN, same stimulus -> hora=0x3A is committed, bcd_error=0.
